// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch handshake between fetch_pc_unit and instruction memory.
interface fetch_pc_unit_if #(
    parameter int ADDR_W = 5
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W+2:0] rdata;
    logic              ack;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output ack
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch / PC stage feeding the accumulator-CPU controller.
// Optional fetch watchdog with FAULT state: define FETCH_TIMEOUT_EN.
module fetch_pc_unit #(
    parameter int ADDR_W   = 5,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_pc_src,
    fetch_pc_unit_if.master   imem,
    output logic [2:0]        o_opcode,
    output logic [ADDR_W-1:0] o_operand_addr,
    output logic              o_instr_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
`ifdef FETCH_TIMEOUT_EN
        , S_FAULT
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W+2:0] r_ir;
    logic              w_ir_load;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;
    logic          w_tmo;

    assign w_tmo = (r_tcnt == TW'(TIMEOUT - 1));

    // Zero whenever outside FETCH, so every FETCH entry starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != S_FETCH) begin
            r_tcnt <= '0;
        end else if (!imem.ack) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_load   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem.ack) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = S_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (w_tmo) begin
                    w_state_nxt = S_FAULT;
                end
`endif
            end
            S_EXEC: begin
                unique case (i_pc_src)
                    2'b01: begin
                        w_pc_nxt    = r_ir[ADDR_W-1:0];
                        w_state_nxt = S_FETCH;
                    end
                    2'b10: begin
                        w_state_nxt = S_EXEC;
                    end
                    default: begin
                        w_pc_nxt    = r_pc + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                endcase
            end
`ifdef FETCH_TIMEOUT_EN
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= ADDR_W'(RESET_PC);
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ir_load) begin
                r_ir <= imem.rdata;
            end
        end
    end

    // Every output decodes registered state only.
    assign imem.req       = (r_state == S_FETCH);
    assign imem.addr      = r_pc;
    assign o_pc           = r_pc;
    assign o_opcode       = r_ir[ADDR_W+2:ADDR_W];
    assign o_operand_addr = r_ir[ADDR_W-1:0];
    assign o_instr_valid  = (r_state == S_EXEC);
`ifdef FETCH_TIMEOUT_EN
    assign o_halted       = (r_state == S_IDLE) || (r_state == S_FAULT);
`else
    assign o_halted       = (r_state == S_IDLE);
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: latency-programmable memory plus instruction-level model.
module tb_fetch_pc_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    pc_src = 2'b00;
    logic [2:0]    opcode;
    logic [AW-1:0] operand_addr;
    logic [AW-1:0] pc;
    logic          instr_valid;
    logic          halted;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [32];
    int  lat = 0;
    bit  force_ack = 1'b0;
    int  wcnt = 0;
    int  exp_pc = 0;

    always #5 clk = ~clk;

    fetch_pc_unit_if #(.ADDR_W(AW)) imem_if ();

    fetch_pc_unit #(
        .ADDR_W   (AW),
        .RESET_PC (0),
        .TIMEOUT  (15)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_pc_src       (pc_src),
        .imem           (imem_if),
        .o_opcode       (opcode),
        .o_operand_addr (operand_addr),
        .o_instr_valid  (instr_valid),
        .o_pc           (pc),
        .o_halted       (halted)
    );

    // Memory: acks after `lat` extra request cycles, driven just after each edge.
    initial begin
        imem_if.ack   = 1'b0;
        imem_if.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                imem_if.ack   = 1'b1;
                imem_if.rdata = 8'hFF;
            end else if (imem_if.req) begin
                if (wcnt >= lat) begin
                    imem_if.ack   = 1'b1;
                    imem_if.rdata = mem[imem_if.addr];
                end else begin
                    imem_if.ack = 1'b0;
                end
                wcnt++;
            end else begin
                imem_if.ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge while in FETCH of exp_pc; leaves at the
    // negedge of the following FETCH. nl = latency for the next fetch.
    task automatic do_instr(input logic [1:0] src, input int holds,
                            input int nl);
        int n;
        int cur;
        int nxt;
        logic [7:0] w;
        cur = lat;
        w   = mem[exp_pc];
        n   = 0;
        while (!instr_valid && n < 40) begin
            chk("fetch_req", 32'(imem_if.req), 1);
            chk("fetch_addr", 32'(imem_if.addr), exp_pc);
            n++;
            @(negedge clk);
        end
        chk("fetch_cycles", n, cur + 1);
        chk("exec_opcode", 32'(opcode), 32'(w[7:5]));
        chk("exec_operand", 32'(operand_addr), 32'(w[4:0]));
        chk("exec_pc", 32'(pc), exp_pc);
        chk("exec_halted", 32'(halted), 0);
        for (int h = 0; h < holds; h++) begin
            pc_src = 2'b10;
            @(negedge clk);
            chk("hold_valid", 32'(instr_valid), 1);
            chk("hold_pc", 32'(pc), exp_pc);
            chk("hold_opcode", 32'(opcode), 32'(w[7:5]));
        end
        pc_src = src;
        lat    = nl;
        nxt    = (src == 2'b01) ? int'(w[4:0]) : (exp_pc + 1) % 32;
        @(negedge clk);
        chk("next_valid", 32'(instr_valid), 0);
        chk("next_req", 32'(imem_if.req), 1);
        chk("next_addr", 32'(imem_if.addr), nxt);
        chk("next_pc", 32'(pc), nxt);
        exp_pc = nxt;
    endtask

    initial begin
        int n;
        logic [1:0] s;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = {3'b000, 5'($urandom)};
        mem[4]  = {3'b100, 5'd17};
        mem[17] = {3'b011, 5'd31};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_if.req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_halted", 32'(halted), 1);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_operand", 32'(operand_addr), 0);

        rst = 1'b0;
        @(negedge clk);
        chk("idle_halted", 32'(halted), 1);
        chk("idle_req", 32'(imem_if.req), 0);

        lat   = 0;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        exp_pc = 0;
        chk("start_halted", 32'(halted), 0);

        do_instr(2'b00, 0, 0);
        do_instr(2'b00, 0, 0);
        do_instr(2'b00, 0, 0);
        do_instr(2'b00, 0, 2);
        do_instr(2'b01, 0, 1);
        chk("jump_pc17", exp_pc, 17);
        do_instr(2'b01, 0, 0);
        do_instr(2'b00, 0, 0);
        chk("wrap_pc0", 32'(pc), 0);
        do_instr(2'b00, 4, 3);
        do_instr(2'b11, 0, 0);

        for (int k = 0; k < 24; k++) begin
            n = $urandom_range(0, 2);
            s = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
            do_instr(s, $urandom_range(0, 2),
                     (k == 23) ? 3 : $urandom_range(0, 3));
        end

        @(negedge clk);
        chk("midfetch_req", 32'(imem_if.req), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_req", 32'(imem_if.req), 0);
        chk("mrst_pc", 32'(pc), 0);
        chk("mrst_halted", 32'(halted), 1);
        chk("mrst_valid", 32'(instr_valid), 0);
        chk("mrst_opcode", 32'(opcode), 0);
        chk("mrst_operand", 32'(operand_addr), 0);
        rst       = 1'b0;
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack_opcode", 32'(opcode), 0);
            chk("stray_ack_halted", 32'(halted), 1);
            chk("stray_ack_req", 32'(imem_if.req), 0);
        end
        force_ack = 1'b0;
        @(negedge clk);

`ifdef FETCH_TIMEOUT_EN
        lat   = 1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (imem_if.req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", n, 15);
        repeat (5) begin
            chk("fault_halted", 32'(halted), 1);
            chk("fault_req", 32'(imem_if.req), 0);
            chk("fault_valid", 32'(instr_valid), 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("fault_rst_pc", 32'(pc), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction fetch and program-counter stage directly upstream of the accumulator-CPU controller. It holds the PC, fetches 8-bit instruction words from instruction memory over a req/ack handshake, and latches each word into an instruction register. It presents the opcode and operand address to the controller and datapath, then applies the controller's pc_src decision to select the next PC. A start-gated state machine sequences reset, fetch, execute and the wait-for-start condition (pc_src = 2'b10).

Parameters:
ADDR_W, 5, PC and operand-address width; instruction word is 3 + ADDR_W bits.
RESET_PC, 0, PC value loaded on reset.
TIMEOUT, 15, fetch-timeout limit in cycles; used only with FETCH_TIMEOUT_EN.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset: synchronous, active-high.
start  input  1  run enable; also routed to the controller.
pc_src  input  2  next-PC select from controller: 00 = PC+1, 01 = jump to operand_addr, 10 = hold, 11 = reserved.
imem_req  output  1  fetch request.
imem_addr  output  ADDR_W  fetch address; equals pc.
imem_rdata  input  3+ADDR_W  instruction word: [top 3] = opcode, [ADDR_W-1:0] = address.
imem_ack  input  1  fetch data valid; sampled only while imem_req = 1.
opcode  output  3  IR opcode field, to controller.
operand_addr  output  ADDR_W  IR address field, to data memory and jump path.
instr_valid  output  1  high in EXEC; the datapath commits controller strobes only when this is high.
pc  output  ADDR_W  current program counter.
halted  output  1  high in IDLE and FAULT.

Behaviour:
- Reset (rst = 1 at a clk edge, in any state, including mid-fetch): pc = RESET_PC, IR = 0 (opcode 000, operand_addr 0), state = IDLE, imem_req = 0, instr_valid = 0, halted = 1. rst overrides all other inputs.
- States: IDLE, FETCH, EXEC, FAULT (FAULT exists only with the macro). Encoding is free.
- IDLE: halted = 1, no request. If start = 1 at an edge, go to FETCH.
- FETCH:
  - imem_req = 1 (Moore output) and imem_addr = pc.
  - At an edge with imem_ack = 1: IR <= imem_rdata, go to EXEC.
  - An ack present in the first FETCH cycle gives a minimum fetch latency of 1 cycle. imem_ack seen while imem_req = 0 is ignored.
- EXEC: instr_valid = 1 for exactly the cycles spent in EXEC. At the edge, act on pc_src:
  - 00: pc <= pc+1, go to FETCH.
  - 01: pc <= operand_addr, go to FETCH.
  - 10: pc unchanged, IR unchanged, stay in EXEC with instr_valid still 1. The controller re-evaluates start each cycle, and the unit leaves EXEC when pc_src changes.
  - 11: treated as 00.
- Back-to-back instruction cadence is FETCH latency + 1 cycles.
- PC arithmetic is modulo 2^ADDR_W: pc = 2^ADDR_W-1 with pc_src 00 wraps to 0. A jump target may equal pc (self-loop is legal).
- start going low during FETCH or EXEC has no effect in this block. Halting is expressed only through pc_src = 10.
- opcode and operand_addr are driven straight from IR and change only on an ack edge or on reset.
- No combinational path from any input to any output.

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to FETCH and increments each FETCH cycle without an ack.
  - If it reaches TIMEOUT, the next state is FAULT: imem_req = 0, instr_valid = 0, halted = 1.
  - FAULT is left only by rst.
- Not defined: no counter and no FAULT state; FETCH waits indefinitely for imem_ack.

Test Plan:
- Reset then start = 1 with 1-cycle ack memory, all words opcode 000 (pc_src 00): pc steps 0,1,2,3; instr_valid pulses once every 2 cycles; opcode/operand_addr match each word.
- EXEC with word {100, 5'd17} and pc_src = 01: next imem_addr = 17, pc = 17.
- pc = 31 (ADDR_W = 5) with pc_src = 00: next fetch from address 0.
- EXEC with pc_src = 10 held for 4 cycles, then 00: instr_valid high for 5 consecutive cycles, pc constant, then pc+1.
- rst asserted during FETCH with ack delayed 3 cycles: imem_req = 0 on the next edge, pc = RESET_PC, halted = 1, and the late ack is ignored.
- FETCH_TIMEOUT_EN, TIMEOUT = 15, ack never asserted: FAULT after 15 FETCH cycles, halted = 1, imem_req = 0 until rst.
